// File: rtl/evr_cfg_pkg.sv
// evr_cfg_pkg: register field codes, CTRL layout, FSM states and per-channel config record
package evr_cfg_pkg;
  localparam logic [1:0] REG_EVENT = 2'd0;
  localparam logic [1:0] REG_DELAY = 2'd1;
  localparam logic [1:0] REG_WIDTH = 2'd2;
  localparam logic [1:0] REG_POL = 2'd3;
  localparam logic [7:0] CTRL_ADDR = 8'hF0;
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_SYNC = 1;
  localparam int CTRL_CLR = 2;
  typedef enum logic [1:0] {IDLE, WAIT_SYNC, WAIT_QUIET, APPLY} state_e;
  typedef struct packed {
    logic [7:0] evt;
    logic [31:0] delay;
    logic [31:0] width;
    logic pol;
  } ch_cfg_t;
  function automatic logic [31:0] field_of(ch_cfg_t c, logic [1:0] r);
    return r == REG_EVENT ? {24'b0, c.evt} : r == REG_DELAY ? c.delay :
           r == REG_WIDTH ? c.width : {31'b0, c.pol};
  endfunction
endpackage

// File: rtl/evr_channel_cfg_ctrl_if.sv
// evr_channel_cfg_ctrl_if: host register bus; EVR_CFG_READBACK_EN adds the read channel
interface evr_channel_cfg_ctrl_if;
  logic cfg_wr;
  logic [7:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic cfg_ack;
`ifdef EVR_CFG_READBACK_EN
  logic cfg_rd;
  logic [31:0] cfg_rdata;
  logic cfg_rvalid;
`endif
  modport master (
    output cfg_wr, cfg_addr, cfg_wdata,
`ifdef EVR_CFG_READBACK_EN
    output cfg_rd,
    input cfg_rdata, cfg_rvalid,
`endif
    input cfg_ack
  );
  modport slave (
    input cfg_wr, cfg_addr, cfg_wdata,
`ifdef EVR_CFG_READBACK_EN
    input cfg_rd,
    output cfg_rdata, cfg_rvalid,
`endif
    output cfg_ack
  );
endinterface

// File: rtl/evr_cfg_shadow_bank.sv
// evr_cfg_shadow_bank: one channel's shadow/active register pair; apply copies the pre-write shadow
module evr_cfg_shadow_bank
  import evr_cfg_pkg::*;
(
  input logic Clock,
  input logic Reset,
  input logic wr_en_i,
  input logic [1:0] reg_i,
  input logic [31:0] wdata_i,
  input logic apply_i,
`ifdef EVR_CFG_READBACK_EN
  output ch_cfg_t shadow_o,
`endif
  output ch_cfg_t active_o
);
  ch_cfg_t shadow_q, shadow_d, active_q, active_d;
  always_comb begin
    shadow_d.evt = (wr_en_i && reg_i == REG_EVENT) ? wdata_i[7:0] : shadow_q.evt;
    shadow_d.delay = (wr_en_i && reg_i == REG_DELAY) ? wdata_i : shadow_q.delay;
    shadow_d.width = (wr_en_i && reg_i == REG_WIDTH) ? wdata_i : shadow_q.width;
    shadow_d.pol = (wr_en_i && reg_i == REG_POL) ? wdata_i[0] : shadow_q.pol;
    active_d = apply_i ? shadow_q : active_q;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end
`ifdef EVR_CFG_READBACK_EN
  assign shadow_o = shadow_q;
`endif
  assign active_o = active_q;
endmodule

// File: rtl/evr_channel_cfg_ctrl.sv
// evr_channel_cfg_ctrl: shadowed trigger-channel config with atomic, safe-point commit.
// Optional EVR_CFG_READBACK_EN adds registered shadow/CTRL readback.
module evr_channel_cfg_ctrl
  import evr_cfg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter logic [7:0] SYNC_EVENT = 8'h7E,
  parameter logic [31:0] QUIET_TIMEOUT = 32'd125000
) (
  input logic Clock,
  input logic Reset,
  input logic [7:0] eventStream,
  evr_channel_cfg_ctrl_if.slave bus,
  input logic [NUM_CH-1:0] ch_busy,
  output logic [8*NUM_CH-1:0] ch_event,
  output logic [32*NUM_CH-1:0] ch_delay,
  output logic [32*NUM_CH-1:0] ch_width,
  output logic [NUM_CH-1:0] ch_polarity,
  output logic commit_pending,
  output logic commit_done,
  output logic timeout_err
);
  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic ack_q, done_q, err_q, err_d, force_apply, ctrl_wr, commit;
  assign ctrl_wr = bus.cfg_wr && bus.cfg_addr == CTRL_ADDR;
  assign commit = ctrl_wr && bus.cfg_wdata[CTRL_COMMIT];
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    force_apply = 1'b0;
    case (state_q)
      IDLE: state_d = commit ? (bus.cfg_wdata[CTRL_SYNC] ? WAIT_SYNC : WAIT_QUIET) : IDLE;
      WAIT_SYNC: state_d = eventStream == SYNC_EVENT ? WAIT_QUIET : WAIT_SYNC;
      WAIT_QUIET: begin
        cnt_d = cnt_q + 32'd1;
        force_apply = |ch_busy && cnt_q == QUIET_TIMEOUT - 32'd1;
        state_d = (!(|ch_busy) || force_apply) ? APPLY : WAIT_QUIET;
      end
      default: state_d = IDLE;
    endcase
    // a forced apply in the same cycle as a W1C still leaves the flag set
    err_d = force_apply | (err_q & ~(ctrl_wr & bus.cfg_wdata[CTRL_CLR]));
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ack_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ack_q <= bus.cfg_wr;
      done_q <= state_q == APPLY;
      err_q <= err_d;
    end
  end
  assign bus.cfg_ack = ack_q;
  assign commit_pending = state_q != IDLE;
  assign commit_done = done_q;
  assign timeout_err = err_q;
`ifdef EVR_CFG_READBACK_EN
  ch_cfg_t shadow [NUM_CH];
  logic [31:0] rdata_q, rdata_d;
  logic rvalid_q;
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.cfg_addr[7:4] == 4'(i)) rdata_d = field_of(shadow[i], bus.cfg_addr[3:2]);
    if (bus.cfg_addr == CTRL_ADDR) rdata_d = {29'b0, err_q, commit_pending, state_q == IDLE};
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rdata_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q <= bus.cfg_rd ? rdata_d : rdata_q;
      rvalid_q <= bus.cfg_rd;
    end
  end
  assign bus.cfg_rdata = rdata_q;
  assign bus.cfg_rvalid = rvalid_q;
`endif
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_cfg_t act;
    // CTRL_ADDR aliases channel 15 / event, so CTRL decode takes priority
    evr_cfg_shadow_bank u_bank (
      .Clock(Clock),
      .Reset(Reset),
      .wr_en_i(bus.cfg_wr && !ctrl_wr && bus.cfg_addr[7:4] == 4'(c)),
      .reg_i(bus.cfg_addr[3:2]),
      .wdata_i(bus.cfg_wdata),
      .apply_i(state_q == APPLY),
`ifdef EVR_CFG_READBACK_EN
      .shadow_o(shadow[c]),
`endif
      .active_o(act)
    );
    assign ch_event[8*c +: 8] = act.evt;
    assign ch_delay[32*c +: 32] = act.delay;
    assign ch_width[32*c +: 32] = act.width;
    assign ch_polarity[c] = act.pol;
  end
endmodule

// File: tb/tb_evr_channel_cfg_ctrl.sv
// tb_evr_channel_cfg_ctrl: directed checks of commit, sync, busy hold, timeout, collisions, reset
module tb_evr_channel_cfg_ctrl;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic [7:0] eventStream = 8'h00;
  logic [3:0] busy = 4'h0, busy_t = 4'h0;
  logic [31:0] ev, ev_t;
  logic [127:0] dl, wd, dl_t, wd_t;
  logic [3:0] pol, pol_t;
  logic pend, done, terr, pend_t, done_t, terr_t;
  int vectors = 0;
  int miscompares = 0;
  int n;
  always #5 Clock = ~Clock;
  evr_channel_cfg_ctrl_if bus ();
  evr_channel_cfg_ctrl_if bus_t ();
  assign bus_t.cfg_wr = bus.cfg_wr;
  assign bus_t.cfg_addr = bus.cfg_addr;
  assign bus_t.cfg_wdata = bus.cfg_wdata;
  evr_channel_cfg_ctrl dut (
    .Clock(Clock), .Reset(Reset), .eventStream(eventStream), .bus(bus), .ch_busy(busy),
    .ch_event(ev), .ch_delay(dl), .ch_width(wd), .ch_polarity(pol),
    .commit_pending(pend), .commit_done(done), .timeout_err(terr)
  );
  evr_channel_cfg_ctrl #(.QUIET_TIMEOUT(32'd16)) dut_t (
    .Clock(Clock), .Reset(Reset), .eventStream(eventStream), .bus(bus_t), .ch_busy(busy_t),
    .ch_event(ev_t), .ch_delay(dl_t), .ch_width(wd_t), .ch_polarity(pol_t),
    .commit_pending(pend_t), .commit_done(done_t), .timeout_err(terr_t)
  );
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.cfg_wr = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_wr = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.cfg_wr = 1'b0;
    bus.cfg_addr = 8'h00;
    bus.cfg_wdata = 32'h0;
    repeat (3) tick();
    Reset = 1'b0;
    chk("rst_event", ev, 0);
    chk("rst_delay", dl, 0);
    chk("rst_flags", {pend, done, terr, bus.cfg_ack}, 0);
    // immediate commit on channel 1
    wr(8'h10, 32'h2A);
    wr(8'h14, 32'd10);
    wr(8'h18, 32'd5);
    wr(8'h1C, 32'h1);
    wr(8'hF0, 32'h1);
    chk("imm_ack", bus.cfg_ack, 1);
    chk("imm_pending", pend, 1);
    chk("imm_not_yet", ev, 0);
    tick();
    chk("imm_apply_cycle", {ev, done}, 0);
    tick();
    chk("imm_event", ev, 32'h0000_2A00);
    chk("imm_delay", dl[63:32], 10);
    chk("imm_width", wd[63:32], 5);
    chk("imm_pol", pol, 4'b0010);
    chk("imm_done", {done, pend}, 2'b10);
    tick();
    chk("imm_done_pulse", done, 0);
    // sync mode
    wr(8'h20, 32'h33);
    wr(8'hF0, 32'h3);
    eventStream = 8'h10;
    repeat (20) tick();
    chk("sync_wait", {pend, done, ev[23:16]}, {2'b10, 8'h00});
    eventStream = 8'h7E;
    tick();
    eventStream = 8'h00;
    tick();
    chk("sync_apply_cycle", ev[23:16], 0);
    tick();
    chk("sync_event", ev[23:16], 8'h33);
    chk("sync_done", done, 1);
    // busy hold
    wr(8'h04, 32'd7);
    busy = 4'b0100;
    wr(8'hF0, 32'h1);
    repeat (50) tick();
    chk("busy_hold", {pend, done, dl[31:0]}, {2'b10, 32'd0});
    busy = 4'b0000;
    tick();
    chk("busy_apply_cycle", dl[31:0], 0);
    tick();
    chk("busy_delay", dl[31:0], 7);
    chk("busy_done_err", {done, terr}, 2'b10);
    // timeout on the short-timeout instance
    busy_t = 4'hF;
    wr(8'hF0, 32'h1);
    repeat (15) tick();
    chk("tmo_before", {pend_t, terr_t}, 2'b10);
    tick();
    chk("tmo_forced", {terr_t, done_t}, 2'b10);
    tick();
    chk("tmo_done", {done_t, pend_t}, 2'b10);
    chk("tmo_main_clean", terr, 0);
    busy_t = 4'h0;
    wr(8'hF0, 32'h4);
    chk("tmo_w1c", terr_t, 0);
    // shadow write in the APPLY cycle
    wr(8'hF0, 32'h1);
    tick();
    wr(8'h04, 32'd99);
    chk("coll_old_delay", dl[31:0], 7);
    chk("coll_done", done, 1);
    wr(8'hF0, 32'h1);
    tick();
    tick();
    chk("coll_new_delay", dl[31:0], 99);
    // second commit while pending
    busy = 4'b0001;
    wr(8'hF0, 32'h1);
    tick();
    wr(8'hF0, 32'h1);
    chk("dbl_ack", bus.cfg_ack, 1);
    busy = 4'b0000;
    n = 0;
    repeat (8) begin
      tick();
      n += int'(done);
    end
    chk("dbl_single_done", n, 1);
    chk("dbl_idle", pend, 0);
    // reset in WAIT_QUIET
    wr(8'h38, 32'd5);
    busy = 4'b1000;
    wr(8'hF0, 32'h1);
    tick();
    chk("rst_mid_pending", pend, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rst_mid_event", ev, 0);
    chk("rst_mid_dw", {dl, wd}, 0);
    chk("rst_mid_flags", {pol, pend, done}, 0);
    n = 0;
    repeat (5) begin
      tick();
      n += int'(done);
    end
    chk("rst_mid_no_done", n, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
